ssd_scan_ctrl: RTL and testbench
================================

Name: ssd_scan_ctrl

Overview:
- Multiplexed display driver that consumes the 15-bit active-low segment patterns produced by the BCD counter/decoder blocks.
- Time-multiplexes DIGITS patterns onto one shared segment bus with per-digit active-low anode selects.
- Takes new digit data through a req/ack handshake and commits it only at a frame boundary, so a frame never mixes old and new digits.

Parameters:
- DIGITS, 4, number of multiplexed digits (≥2)
- SEG_W, 15, segment pattern width per digit (active-low, bit=0 lights segment)
- SCAN_DIV, 25000, clk cycles per digit slot (> GUARD+1)
- GUARD, 2, clk cycles at the start of each slot with all anodes off (anti-ghosting)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- digit_seg_in  in  DIGITS*SEG_W  digit patterns; digit k = bits [k*SEG_W +: SEG_W]
- blank_mask  in  DIGITS  1 = force digit k dark
- upd_req  in  1  requester holds high, with digit_seg_in/blank_mask stable, until upd_ack
- upd_ack  out  1  one-cycle pulse: shadow registers loaded
- seg_out  out  SEG_W  shared segment bus, active-low
- an_out  out  DIGITS  anode selects, active-low, at most one low
- frame_start  out  1  one-cycle pulse when digit 0's slot begins

Behaviour:
- Clock clk; reset rst_n is asynchronous, active-low. Reset mid-operation clears all state immediately, regardless of handshake or scan phase.
- Reset values:
  - seg_out = all 1, an_out = all 1, upd_ack = 0, frame_start = 0
  - shadow patterns = all 1, shadow blank = all 1 (display dark until first update)
  - div_cnt = 0, dig_idx = 0
- Prescaler: div_cnt counts 0..SCAN_DIV-1 and wraps. tick = (div_cnt == SCAN_DIV-1).
- On tick: dig_idx advances 0..DIGITS-1 and wraps to 0. frame_tick = tick && dig_idx == DIGITS-1.
- Outputs are registered; the values below apply from the edge after the state change.
  - seg_out = shadow pattern[dig_idx], or all 1 if shadow blank[dig_idx] is set.
  - an_out[dig_idx] = 0 only when div_cnt ≥ GUARD and the digit is not blanked; all other anode bits are 1.
  - During guard cycles an_out = all 1; seg_out already shows the new digit.
- frame_start is high for exactly the first cycle in which dig_idx == 0 (the cycle after frame_tick).
- Handshake:
  - If upd_req = 1 at the frame_tick edge, the shadow registers load digit_seg_in and blank_mask on that edge, and upd_ack = 1 for the following cycle only.
  - New data is first visible in digit 0's slot.
  - upd_req is level-sensitive: if still high at the next frame_tick, a second load and ack occur.
  - upd_req high outside frame_tick has no effect; it waits, with no timeout.
  - Data is not registered before the load, so changing inputs while req is pending loads whatever is present at the frame_tick edge.
- Update latency: at most DIGITS*SCAN_DIV cycles from req to ack.
- Width rules: div_cnt width = $clog2(SCAN_DIV); dig_idx width = $clog2(DIGITS). No other arithmetic.

Optional Feature:
- Macro SSD_DIM_EN.
- Defined:
  - Adds input port duty [3:0] and a free-running 4-bit pwm_cnt (reset 0, increments every clk).
  - The anode is active only when the undimmed condition holds and pwm_cnt < duty.
  - duty = 0 gives fully dark; duty = 15 gives 15/16 on-time.
  - seg_out is unaffected.
- Undefined: no duty port, no pwm_cnt, full brightness.

Decomposition:
- Package ssd_pkg:
  - SEG_OFF constant (all-ones SEG_W pattern)
  - default DIGITS/SEG_W localparams
  - typedef seg_t (logic [SEG_W-1:0])
- Sub-module ssd_scan_timer: prescaler plus digit index; outputs dig_idx, div_cnt, tick, frame_tick.
- The top module keeps the shadow registers, handshake, and output muxing.

Test Plan (SCAN_DIV=4, GUARD=1, DIGITS=4):
- Reset release, no update -> an_out = 4'b1111 and seg_out = all 1 for 64 cycles; frame_start pulses every 16 cycles.
- upd_req with patterns 15'h0001/15'h0002/15'h0004/15'h0008, blank_mask 0 -> upd_ack one cycle after the first frame_tick. Each digit slot then shows its pattern with an_out = 1110/1101/1011/0111, each low for 3 of 4 cycles.
- blank_mask = 4'b0100 after update -> the digit-2 slot has an_out = 1111 and seg_out = all 1; other digits are unchanged.
- upd_req held high for 40 cycles -> exactly two or three acks, each a one-cycle pulse aligned one cycle after a frame_tick; none at any other time.
- rst_n pulsed low mid-slot with req pending -> outputs go all 1 immediately; no ack is issued; the shadow registers are dark after release.
- With SSD_DIM_EN and duty = 0 -> an_out stays 1111. With duty = 8 -> anode low 8 of every 16 non-guard cycles.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants and types for the multiplexed seven/fifteen-segment display driver.
package ssd_pkg;

  localparam int DEF_DIGITS = 4;
  localparam int DEF_SEG_W  = 15;

  typedef logic [DEF_SEG_W-1:0] seg_t;

  localparam seg_t SEG_OFF = '1;

endpackage

// File: rtl/ssd_scan_timer.sv
// Scan timebase: per-slot prescaler and digit index, with slot and frame end strobes.
module ssd_scan_timer #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 25000,
  parameter int CNT_W    = $clog2(SCAN_DIV),
  parameter int IDX_W    = $clog2(DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] div_cnt,
  output logic [IDX_W-1:0] dig_idx,
  output logic             tick,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  assign tick       = (div_cnt == DIV_LAST);
  assign frame_tick = tick && (dig_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else begin
      if (tick) div_cnt <= '0;
      else      div_cnt <= div_cnt + CNT_W'(1);
      // Explicit wrap so non-power-of-two digit counts still cycle correctly
      if (frame_tick) dig_idx <= '0;
      else if (tick)  dig_idx <= dig_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed display driver with frame-aligned req/ack shadow update.
// Optional build macro SSD_DIM_EN adds a 4-bit duty input for PWM dimming of the anodes.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int DIGITS   = DEF_DIGITS,
  parameter int SEG_W    = DEF_SEG_W,
  parameter int SCAN_DIV = 25000,
  parameter int GUARD    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef SSD_DIM_EN
  input  logic [3:0]              duty,
`endif
  input  logic [DIGITS*SEG_W-1:0] digit_seg_in,
  input  logic [DIGITS-1:0]       blank_mask,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic [SEG_W-1:0]        seg_out,
  output logic [DIGITS-1:0]       an_out,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

  logic [CNT_W-1:0]             div_cnt;
  logic [IDX_W-1:0]             dig_idx;
  logic                         tick;
  logic                         frame_tick;
  logic                         load;
  logic                         pwm_ok;
  logic [DIGITS-1:0][SEG_W-1:0] shadow_pat;
  logic [DIGITS-1:0]            shadow_blank;
  logic [SEG_W-1:0]             seg_p0;
  logic [DIGITS-1:0]            an_p0;

  ssd_scan_timer #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W),
    .IDX_W    (IDX_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_cnt    (div_cnt),
    .dig_idx    (dig_idx),
    .tick       (tick),
    .frame_tick (frame_tick)
  );

  // Shadow commit happens only on the last cycle of the final slot
  assign load = tick && frame_tick && upd_req;

`ifdef SSD_DIM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign pwm_ok = (pwm_cnt < duty);
`else
  assign pwm_ok = 1'b1;
`endif

  // p0: select current digit; anode held off through the guard window
  always_comb begin
    seg_p0 = shadow_blank[dig_idx] ? {SEG_W{1'b1}} : shadow_pat[dig_idx];
    an_p0  = '1;
    if ((div_cnt >= GUARD_C) && !shadow_blank[dig_idx] && pwm_ok)
      an_p0[dig_idx] = 1'b0;
  end

  // Output register stage and shadow bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out      <= {SEG_W{1'b1}};
      an_out       <= '1;
      upd_ack      <= 1'b0;
      frame_start  <= 1'b0;
      shadow_pat   <= {(DIGITS*SEG_W){1'b1}};
      shadow_blank <= '1;
    end else begin
      seg_out     <= seg_p0;
      an_out      <= an_p0;
      upd_ack     <= load;
      frame_start <= frame_tick;
      if (load) begin
        shadow_pat   <= digit_seg_in;
        shadow_blank <= blank_mask;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl with SCAN_DIV=4, GUARD=1, DIGITS=4.
module tb_ssd_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int SEG_W    = 15;
  localparam int SCAN_DIV = 4;
  localparam int GUARD    = 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [DIGITS*SEG_W-1:0] digit_seg_in = '0;
  logic [DIGITS-1:0]       blank_mask = '0;
  logic                    upd_req = 1'b0;
  logic                    upd_ack;
  logic [SEG_W-1:0]        seg_out;
  logic [DIGITS-1:0]       an_out;
  logic                    frame_start;
`ifdef SSD_DIM_EN
  logic [3:0]              duty = 4'd15;
`endif

  ssd_scan_ctrl #(
    .DIGITS   (DIGITS),
    .SEG_W    (SEG_W),
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef SSD_DIM_EN
    .duty         (duty),
`endif
    .digit_seg_in (digit_seg_in),
    .blank_mask   (blank_mask),
    .upd_req      (upd_req),
    .upd_ack      (upd_ack),
    .seg_out      (seg_out),
    .an_out       (an_out),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SEG_W-1:0]  seg;
    logic [DIGITS-1:0] an;
    logic              ack;
    logic              fs;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             exp_cur;
  int               m_div, m_idx, m_pwm;
  logic [SEG_W-1:0] m_pat[DIGITS];
  logic [DIGITS-1:0] m_blank;
  int               n_checks = 0;
  int               n_pass = 0;

  task automatic model_reset();
    m_div = 0;
    m_idx = 0;
    m_pwm = 0;
    for (int k = 0; k < DIGITS; k++) m_pat[k] = '1;
    m_blank = '1;
    sb_q.delete();
  endtask

  // Expected outputs after the coming edge, from the pre-edge model state and inputs
  task automatic model_step();
    exp_t e;
    logic ft;
    logic on;
    ft    = (m_div == SCAN_DIV - 1) && (m_idx == DIGITS - 1);
    e.seg = m_blank[m_idx] ? '1 : m_pat[m_idx];
    e.an  = '1;
    on    = (m_div >= GUARD) && !m_blank[m_idx];
`ifdef SSD_DIM_EN
    on    = on && (m_pwm < int'(duty));
`endif
    if (on) e.an[m_idx] = 1'b0;
    e.ack = ft && upd_req;
    e.fs  = ft;
    if (e.ack) begin
      for (int k = 0; k < DIGITS; k++) m_pat[k] = digit_seg_in[k*SEG_W +: SEG_W];
      m_blank = blank_mask;
    end
    if (m_div == SCAN_DIV - 1) begin
      m_div = 0;
      m_idx = (m_idx + 1) % DIGITS;
    end else begin
      m_div = m_div + 1;
    end
    m_pwm = (m_pwm + 1) % 16;
    sb_q.push_back(e);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    exp_cur = sb_q.pop_front();
  endtask

  task automatic test_reset();
    int fs_cnt;
    int lit;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({seg_out, an_out} !== {{SEG_W{1'b1}}, {DIGITS{1'b1}}})
      $display("FAIL rst_outputs seg/an=%h/%b expected all ones", seg_out, an_out);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({upd_ack, frame_start} !== 2'b00)
      $display("FAIL rst_pulses ack/fs=%b%b expected 00", upd_ack, frame_start);
    else n_pass++;
    rst_n = 1'b1;
    model_reset();
    fs_cnt = 0;
    lit = 0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      n_checks++;
      if ({seg_out, an_out} !== {exp_cur.seg, exp_cur.an})
        $display("FAIL idle_disp cyc%0d seg/an=%h/%b expected %h/%b", i, seg_out, an_out, exp_cur.seg, exp_cur.an);
      else n_pass++;
      n_checks++;
      if ({upd_ack, frame_start} !== {exp_cur.ack, exp_cur.fs})
        $display("FAIL idle_pulse cyc%0d ack/fs=%b%b expected %b%b", i, upd_ack, frame_start, exp_cur.ack, exp_cur.fs);
      else n_pass++;
      if (frame_start) fs_cnt++;
      if (an_out != '1 || seg_out != '1) lit++;
    end
    n_checks++;
    if (fs_cnt !== 4) $display("FAIL idle_fs_count got %0d expected 4", fs_cnt);
    else n_pass++;
    n_checks++;
    if (lit !== 0) $display("FAIL idle_dark lit cycles %0d expected 0", lit);
    else n_pass++;
  endtask

  // Load digit_seg_in/blank_mask and examine the first full frame that shows them
  task automatic run_update(input logic [DIGITS-1:0] bm, input string tag);
    int got;
    int lows[DIGITS];
    int bad;
    logic [SEG_W-1:0] pat;
    digit_seg_in = {15'h0008, 15'h0004, 15'h0002, 15'h0001};
    blank_mask   = bm;
    upd_req      = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      cycle();
      n_checks++;
      if ({seg_out, an_out, upd_ack, frame_start} !== exp_cur)
        $display("FAIL %s_wait cyc%0d seg/an/ack/fs=%h/%b/%b/%b expected %h/%b/%b/%b", tag, i,
                 seg_out, an_out, upd_ack, frame_start, exp_cur.seg, exp_cur.an, exp_cur.ack, exp_cur.fs);
      else n_pass++;
      if (upd_ack === 1'b1) begin
        got = 1;
        upd_req = 1'b0;
      end
    end
    n_checks++;
    if (got !== 1) $display("FAIL %s_ack_seen got %0d expected 1", tag, got);
    else n_pass++;
    for (int k = 0; k < DIGITS; k++) lows[k] = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      n_checks++;
      if ({seg_out, an_out, upd_ack, frame_start} !== exp_cur)
        $display("FAIL %s_frame cyc%0d seg/an/ack/fs=%h/%b/%b/%b expected %h/%b/%b/%b", tag, i,
                 seg_out, an_out, upd_ack, frame_start, exp_cur.seg, exp_cur.an, exp_cur.ack, exp_cur.fs);
      else n_pass++;
      pat = bm[i/4] ? '1 : (15'h0001 << (i/4));
      if (seg_out !== pat) bad++;
      for (int k = 0; k < DIGITS; k++) if (an_out[k] === 1'b0) lows[k]++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL %s_slot_seg wrong cycles %0d expected 0", tag, bad);
    else n_pass++;
`ifndef SSD_DIM_EN
    for (int k = 0; k < DIGITS; k++) begin
      n_checks++;
      if (lows[k] !== (bm[k] ? 0 : SCAN_DIV - GUARD))
        $display("FAIL %s_an%0d_low got %0d expected %0d", tag, k, lows[k], bm[k] ? 0 : SCAN_DIV - GUARD);
      else n_pass++;
    end
`endif
  endtask

  task automatic test_update();
    run_update(4'b0000, "update");
  endtask

  task automatic test_blank();
    run_update(4'b0100, "blank");
  endtask

  task automatic test_back_to_back();
    int acks;
    int dbl;
    logic prev;
    digit_seg_in = {15'h7FF0, 15'h7F0F, 15'h70FF, 15'h0FFF};
    blank_mask   = 4'b0000;
    upd_req      = 1'b1;
    acks = 0;
    dbl  = 0;
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n_checks++;
      if ({seg_out, an_out, upd_ack, frame_start} !== exp_cur)
        $display("FAIL b2b cyc%0d seg/an/ack/fs=%h/%b/%b/%b expected %h/%b/%b/%b", i,
                 seg_out, an_out, upd_ack, frame_start, exp_cur.seg, exp_cur.an, exp_cur.ack, exp_cur.fs);
      else n_pass++;
      if (upd_ack === 1'b1) acks++;
      if (prev && upd_ack === 1'b1) dbl++;
      prev = (upd_ack === 1'b1);
    end
    upd_req = 1'b0;
    n_checks++;
    if (acks < 2 || acks > 3) $display("FAIL b2b_ack_count got %0d expected 2..3", acks);
    else n_pass++;
    n_checks++;
    if (dbl !== 0) $display("FAIL b2b_ack_width stretched acks %0d expected 0", dbl);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lit;
    int guard_n;
    guard_n = 0;
    while (!(m_div == 1 && m_idx == 1) && guard_n < 32) begin
      cycle();
      guard_n++;
    end
    digit_seg_in = {15'h1111, 15'h2222, 15'h3333, 15'h4444};
    blank_mask   = 4'b0000;
    upd_req      = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (an_out === '1) $display("FAIL rmid_pre_lit an=%b expected one anode low", an_out);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({seg_out, an_out, upd_ack, frame_start} !== {{SEG_W{1'b1}}, {DIGITS{1'b1}}, 2'b00})
      $display("FAIL rmid_async seg/an/ack/fs=%h/%b/%b/%b expected all ones, 0, 0",
               seg_out, an_out, upd_ack, frame_start);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (upd_ack !== 1'b0) $display("FAIL rmid_no_ack ack=%b expected 0", upd_ack);
    else n_pass++;
    upd_req = 1'b0;
    rst_n = 1'b1;
    model_reset();
    lit = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_checks++;
      if ({seg_out, an_out, upd_ack, frame_start} !== exp_cur)
        $display("FAIL rmid_after cyc%0d seg/an/ack/fs=%h/%b/%b/%b expected %h/%b/%b/%b", i,
                 seg_out, an_out, upd_ack, frame_start, exp_cur.seg, exp_cur.an, exp_cur.ack, exp_cur.fs);
      else n_pass++;
      if (an_out != '1 || seg_out != '1 || upd_ack) lit++;
    end
    n_checks++;
    if (lit !== 0) $display("FAIL rmid_dark active cycles %0d expected 0", lit);
    else n_pass++;
  endtask

`ifdef SSD_DIM_EN
  task automatic test_dim();
    int lows;
    run_update(4'b0000, "dimload");
    duty = 4'd0;
    lows = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      n_checks++;
      if ({seg_out, an_out, upd_ack, frame_start} !== exp_cur)
        $display("FAIL dim0 cyc%0d seg/an=%h/%b expected %h/%b", i, seg_out, an_out, exp_cur.seg, exp_cur.an);
      else n_pass++;
      if (an_out != '1) lows++;
    end
    n_checks++;
    if (lows !== 0) $display("FAIL dim0_dark lit cycles %0d expected 0", lows);
    else n_pass++;
    duty = 4'd8;
    for (int i = 0; i < 64; i++) begin
      cycle();
      n_checks++;
      if ({seg_out, an_out, upd_ack, frame_start} !== exp_cur)
        $display("FAIL dim8 cyc%0d seg/an=%h/%b expected %h/%b", i, seg_out, an_out, exp_cur.seg, exp_cur.an);
      else n_pass++;
    end
    duty = 4'd15;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_update();
    test_blank();
    test_back_to_back();
    test_reset_mid();
`ifdef SSD_DIM_EN
    test_dim();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
